idct2d_seq: RTL

// - 8x8 2-D inverse DCT; inverse of dct2d. Takes a block of 64 signed DCT coefficients, returns 64 signed samples.
// - Row-column decomposition on ONE shared 8-point 1-D IDCT datapath, iterated 16 times (8 rows, then 8 columns) through an internal 8x8 transpose buffer.
// - Sits on the decode side of the approximate-adder image pipeline; valid/ready on both ends.

---
 rtl/idct2d_seq_if.sv | 14 +
 rtl/idct2d_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/idct2d_seq_if.sv
// Block-level valid/ready bus of the 8x8 inverse DCT: one coefficient block in, one sample block out.
interface idct2d_seq_if #(parameter int N = 16);
    logic            in_valid;
    logic            in_ready;
    logic [N*64-1:0] data_in;
    logic            out_valid;
    logic            out_ready;
    logic [N*64-1:0] data_out;

    modport master (output in_valid, data_in, out_ready,
                    input  in_ready, out_valid, data_out);
    modport slave  (input  in_valid, data_in, out_ready,
                    output in_ready, out_valid, data_out);
endinterface

// File: rtl/idct2d_seq.sv
// 8x8 2-D inverse DCT: one shared 8-point 1-D IDCT run over 8 rows then 8 columns,
// transposing on every write so both passes read rows.

// One output point n=LANE of the 8-point 1-D IDCT, with rounding and saturation.
module idct_lane #(
    parameter int N    = 16,
    parameter int FRAC = 8,
    parameter int LANE = 0
) (
    input  logic [7:0][N-1:0] x,
    output logic [N-1:0]      y
);
    localparam int P = N + FRAC + 1;
    localparam int W = N + FRAC + 4;
    localparam logic signed [W-1:0] MAXV = W'((1 << (N-1)) - 1);
    localparam logic signed [W-1:0] MINV = ~MAXV;

    // K[k][n] = round(2^8 * 0.5*c(k)*cos((2n+1)k*pi/16)); magnitudes are for FRAC=8.
    function automatic logic signed [FRAC:0] kcoef(input int k, input int n);
        int m;
        int mag;
        logic neg;
        logic signed [FRAC:0] r;
        m = ((2*n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        neg = (m > 8);
        if (neg) m = 16 - m;
        case (m)
            1:       mag = 126;
            2:       mag = 118;
            3:       mag = 106;
            4:       mag = 91;
            5:       mag = 71;
            6:       mag = 49;
            7:       mag = 25;
            default: mag = 0;
        endcase
        if (k == 0) begin
            mag = 91;
            neg = 1'b0;
        end
        r = (FRAC+1)'(mag);
        if (neg) r = -r;
        return r;
    endfunction

    logic signed [W-1:0] acc, rnd, shr;

    always_comb begin
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            logic signed [P-1:0] p;
            p   = P'($signed(x[k])) * P'(kcoef(k, LANE));
            acc = acc + W'(p);
        end
        rnd = acc + W'(1 << (FRAC-1));
        shr = rnd >>> FRAC;
        if (shr > MAXV)      y = MAXV[N-1:0];
        else if (shr < MINV) y = MINV[N-1:0];
        else                 y = shr[N-1:0];
    end
endmodule

module idct2d_seq #(
    parameter int N    = 16,
    parameter int FRAC = 8
) (
    input logic       clk,
    input logic       rst,
    idct2d_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

    state_t                  state, state_next;
    logic [2:0]              idx;
    logic [7:0][7:0][N-1:0]  buf_a, buf_b, dout;
    logic [7:0][N-1:0]       lane_x, lane_y;

    // Both passes feed a row; the column pass reads the transposed copy in buf_b.
    assign lane_x = (state == COL) ? buf_b[idx] : buf_a[idx];

    generate
        for (genvar n = 0; n < 8; n++) begin : g_lane
            idct_lane #(.N(N), .FRAC(FRAC), .LANE(n)) u_lane (
                .x (lane_x),
                .y (lane_y[n])
            );
        end
    endgenerate

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.data_out  = dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid)  state_next = ROW;
            ROW:  if (idx == 3'd7)   state_next = COL;
            COL:  if (idx == 3'd7)   state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            buf_a <= '0;
            buf_b <= '0;
            dout  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    buf_a <= bus.data_in;
                    idx   <= '0;
                end
                ROW: begin
                    for (int n = 0; n < 8; n++) buf_b[n][idx] <= lane_y[n];
                    idx <= idx + 3'd1;
                end
                COL: begin
                    for (int n = 0; n < 8; n++) dout[n][idx] <= lane_y[n];
                    idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
